// File: rtl/cpu_top_pkg.sv
// Shared constants for the keyboard-driven display system: memory map,
// PS/2 scan codes, key-status bit positions and 640x480 VGA timing.
package cpu_top_pkg;

  localparam logic [15:0] STATUS_ADDR = 16'h03F0;
  localparam int          MEM_WORDS   = 1024;
  localparam logic [15:0] PS2_TIMEOUT = 16'd50000;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [2:0] KEY_W     = 3'd0;
  localparam logic [2:0] KEY_A     = 3'd1;
  localparam logic [2:0] KEY_S     = 3'd2;
  localparam logic [2:0] KEY_D     = 3'd3;
  localparam logic [2:0] KEY_SPACE = 3'd4;
  localparam logic [2:0] KEY_R     = 3'd5;

  // Horizontal: 640 visible, 16 front porch, 96 sync, 48 back porch
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd752;
  localparam logic [9:0] H_LAST       = 10'd799;
  // Vertical: 480 visible, 10 front porch, 2 sync, 33 back porch
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd492;
  localparam logic [9:0] V_LAST       = 10'd524;

  typedef enum logic {
    SEQ_CLEAR,
    SEQ_IDLE
  } seq_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_slot_t;

  // Map a scan code to its key-status bit; hit=0 for untracked codes
  function automatic key_slot_t key_lookup(input logic [7:0] code);
    key_slot_t s;
    s.hit = 1'b1;
    s.idx = KEY_W;
    case (code)
      SC_W:     s.idx = KEY_W;
      SC_A:     s.idx = KEY_A;
      SC_S:     s.idx = KEY_S;
      SC_D:     s.idx = KEY_D;
      SC_SPACE: s.idx = KEY_SPACE;
      SC_R:     s.idx = KEY_R;
      default:  s.hit = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cpu_top_mem.sv
// Memory/control block: 1024x16 BRAM on Port A with a clear-after-reset
// sequencer and a read-only key-status register mapped at STATUS_ADDR.
module cpu_mem
  import cpu_top_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [5:0]  key_status,
  output logic [15:0] o_rd_data
);

  logic [15:0] mem_addr;
  logic        mem_WE;
  logic [15:0] mem_dout;

  seq_state_t  r_state;
  seq_state_t  w_next_state;
  logic [9:0]  r_clr_addr;
  logic [15:0] r_mem [MEM_WORDS];
  logic [15:0] r_rd_data;
  logic        r_rd_status;
  logic [5:0]  r_status_q;

  // Sequencer state and clear-address counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= SEQ_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == SEQ_CLEAR) r_clr_addr <= r_clr_addr + 10'd1;
    end
  end

  // Clear every word once, then park Port A on the status register
  always_comb begin
    w_next_state = r_state;
    mem_WE       = 1'b0;
    mem_addr     = STATUS_ADDR;
    case (r_state)
      SEQ_CLEAR: begin
        mem_WE   = 1'b1;
        mem_addr = {6'b0, r_clr_addr};
        if (r_clr_addr == '1) w_next_state = SEQ_IDLE;
      end
      default: ;
    endcase
  end

  // BRAM write port; the status address is not backed by storage
  always_ff @(posedge i_clk) begin
    if (mem_WE && (mem_addr != STATUS_ADDR)) r_mem[mem_addr[9:0]] <= '0;
  end

  // Registered read with status-register overlay
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data   <= '0;
      r_rd_status <= 1'b0;
      r_status_q  <= '0;
    end else begin
      r_rd_data   <= r_mem[mem_addr[9:0]];
      r_rd_status <= (mem_addr == STATUS_ADDR);
      r_status_q  <= key_status;
    end
  end

  assign mem_dout  = r_rd_status ? {10'b0, r_status_q} : r_rd_data;
  assign o_rd_data = mem_dout;

endmodule

// File: rtl/cpu_top_ps2_keys.sv
// PS/2 keyboard receiver plus make/break decoder tracking W/A/S/D/Space/R.
module ps2_keys
  import cpu_top_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [5:0] key_status_out
);

  logic [2:0]  r_clk_sync;   // [1:0] synchroniser, [2] previous synchronised value
  logic [1:0]  r_dat_sync;
  logic [3:0]  r_bit_cnt;
  logic [9:0]  r_shift;
  logic [15:0] r_idle;
  logic [7:0]  scan_code;
  logic        scan_ready;
  logic        break_pending;
  logic [5:0]  r_status;

  logic        w_fall;
  logic [10:0] w_frame;
  logic        w_frame_ok;
  key_slot_t   w_slot;

  assign w_fall  = r_clk_sync[2] & ~r_clk_sync[1];
  // Frame as it stands once the 11th bit arrives: {stop, parity, data, start}
  assign w_frame = {r_dat_sync[1], r_shift};
  assign w_frame_ok = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);
  assign w_slot  = key_lookup(scan_code);
  assign key_status_out = r_status;

  // Synchronise the asynchronous keyboard lines
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
    end
  end

  // Frame assembly, validation and idle timeout
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_idle     <= '0;
      scan_code  <= '0;
      scan_ready <= 1'b0;
    end else begin
      scan_ready <= 1'b0;
      if (w_fall) begin
        r_idle <= '0;
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= '0;
          if (w_frame_ok) begin
            scan_code  <= w_frame[8:1];
            scan_ready <= 1'b1;
          end
        end else begin
          r_shift   <= {r_dat_sync[1], r_shift[9:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (r_bit_cnt != '0) begin
        if (r_idle == PS2_TIMEOUT - 16'd1) begin
          r_bit_cnt <= '0;
          r_idle    <= '0;
        end else begin
          r_idle <= r_idle + 16'd1;
        end
      end
    end
  end

  // Make/break decoding into the live key-status bits
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      break_pending <= 1'b0;
      r_status      <= '0;
    end else if (scan_ready) begin
      if (scan_code == SC_BREAK) begin
        break_pending <= 1'b1;
      end else if (scan_code != SC_EXT) begin
        break_pending <= 1'b0;
        if (w_slot.hit) r_status[w_slot.idx] <= ~break_pending;
      end
    end
  end

endmodule

// File: rtl/cpu_top.sv
// Top level: PS/2 key tracking, memory/control block and 640x480 VGA stage
// colouring the active area from the live key state.
module cpu_top
  import cpu_top_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       VGA_SYNC,
  output logic       VGA_CLK,
  output logic       VGA_BLANK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B
);

  logic [5:0]  w_key_status;
  logic [15:0] w_unused_rd_data;
  logic        w_active;

  logic        r_pix_en;
  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic        r_hs;
  logic        r_vs;
  logic        r_blank;
  logic [3:0]  r_r;
  logic [3:0]  r_g;
  logic [3:0]  r_b;

  ps2_keys uPS2 (
    .i_clk          (CLOCK_50),
    .i_rst          (KEY0),
    .i_ps2_clk      (PS2_CLK),
    .i_ps2_dat      (PS2_DAT),
    .key_status_out (w_key_status)
  );

  cpu_mem uCPU (
    .i_clk      (CLOCK_50),
    .i_rst      (KEY0),
    .key_status (w_key_status),
    .o_rd_data  (w_unused_rd_data)
  );

  assign w_active = (r_h_cnt < H_VISIBLE) && (r_v_cnt < V_VISIBLE);

  // Pixel enable at half rate plus horizontal/vertical counters
  always_ff @(posedge CLOCK_50 or posedge KEY0) begin
    if (KEY0) begin
      r_pix_en <= 1'b0;
      r_h_cnt  <= '0;
      r_v_cnt  <= '0;
    end else begin
      r_pix_en <= ~r_pix_en;
      if (r_pix_en) begin
        if (r_h_cnt == H_LAST) begin
          r_h_cnt <= '0;
          r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
      end
    end
  end

  // Registered sync, blank and colour outputs
  always_ff @(posedge CLOCK_50 or posedge KEY0) begin
    if (KEY0) begin
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_blank <= 1'b0;
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
    end else begin
      r_hs    <= ~((r_h_cnt >= H_SYNC_START) && (r_h_cnt < H_SYNC_END));
      r_vs    <= ~((r_v_cnt >= V_SYNC_START) && (r_v_cnt < V_SYNC_END));
      r_blank <= w_active;
      r_r     <= (w_active && (w_key_status[KEY_W] || w_key_status[KEY_SPACE])) ? 4'hF : 4'h0;
      r_g     <= (w_active && (w_key_status[KEY_A] || w_key_status[KEY_R]))     ? 4'hF : 4'h0;
      r_b     <= (w_active && (w_key_status[KEY_S] || w_key_status[KEY_D]))     ? 4'hF : 4'h0;
    end
  end

  assign VGA_SYNC  = 1'b0;
  assign VGA_CLK   = r_pix_en;
  assign VGA_BLANK = r_blank;
  assign VGA_HS    = r_hs;
  assign VGA_VS    = r_vs;
  assign VGA_R     = r_r;
  assign VGA_G     = r_g;
  assign VGA_B     = r_b;

endmodule

// File: tb/tb_cpu_top.sv
// Self-checking bench for cpu_top: bit-banged PS/2 frames (directed and
// random) checked against a held-key model, plus memory-init and VGA checks.
module tb_cpu_top;

  logic       CLOCK_50 = 1'b0;
  logic       KEY0     = 1'b1;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic       VGA_SYNC, VGA_CLK, VGA_BLANK, VGA_HS, VGA_VS;
  logic [3:0] VGA_R, VGA_G, VGA_B;

  cpu_top dut (
    .CLOCK_50  (CLOCK_50),
    .KEY0      (KEY0),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .VGA_SYNC  (VGA_SYNC),
    .VGA_CLK   (VGA_CLK),
    .VGA_BLANK (VGA_BLANK),
    .VGA_HS    (VGA_HS),
    .VGA_VS    (VGA_VS),
    .VGA_R     (VGA_R),
    .VGA_G     (VGA_G),
    .VGA_B     (VGA_B)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks  = 0;
  int n_fail    = 0;
  int ready_cnt = 0;
  int exp_ready = 0;
  int we_cnt    = 0;

  // Reference model: which keys are held, and whether the next key is a release
  bit held [6];
  bit release_next;

  always @(posedge CLOCK_50) begin
    if (dut.uPS2.scan_ready === 1'b1) ready_cnt++;
    if (KEY0 === 1'b0 && dut.uCPU.mem_WE === 1'b1) we_cnt++;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
  endtask

  function automatic int key_bit(input logic [7:0] code);
    case (code)
      8'h1D: return 0;
      8'h1C: return 1;
      8'h1B: return 2;
      8'h23: return 3;
      8'h29: return 4;
      8'h2D: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic logic [5:0] model_status();
    logic [5:0] s;
    for (int i = 0; i < 6; i++) s[i] = held[i];
    return s;
  endfunction

  task automatic model_apply(input logic [7:0] code);
    int k;
    if (code == 8'hF0) begin
      release_next = 1'b1;
    end else if (code != 8'hE0) begin
      k = key_bit(code);
      if (k >= 0) held[k] = !release_next;
      release_next = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) held[i] = 1'b0;
    release_next = 1'b0;
  endtask

  // Drive up to nbits of an 11-bit frame; optionally corrupt parity
  task automatic send_bits(input logic [7:0] code, input bit bad_par, input int nbits);
    logic [10:0] f;
    f[0]    = 1'b0;
    f[8:1]  = code;
    f[9]    = (~^code) ^ bad_par;
    f[10]   = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      PS2_DAT = f[i];
      cyc(10);
      PS2_CLK = 1'b0;
      cyc(10);
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
    cyc(30);
  endtask

  task automatic check_status(input string tag);
    logic [5:0] m;
    m = model_status();
    @(negedge CLOCK_50);
    check({tag, "_ps2"}, {26'b0, dut.uPS2.key_status_out}, {26'b0, m});
    check({tag, "_cpu"}, {26'b0, dut.uCPU.key_status}, {26'b0, m});
    check({tag, "_mem"}, {16'b0, dut.uCPU.mem_dout}, {16'b0, 10'b0, m});
  endtask

  task automatic do_frame(input logic [7:0] code, input bit bad_par, input string tag);
    send_bits(code, bad_par, 11);
    if (!bad_par) begin
      model_apply(code);
      exp_ready++;
    end
    @(negedge CLOCK_50);
    check({tag, "_ready_cnt"}, ready_cnt, exp_ready);
    if (!bad_par) check({tag, "_code"}, {24'b0, dut.uPS2.scan_code}, {24'b0, code});
    check_status(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLOCK_50);
    KEY0 = 1'b1;
    cyc(3);
    @(negedge CLOCK_50);
    model_reset();
    check({tag, "_rst_status"}, {26'b0, dut.uPS2.key_status_out}, 32'd0);
    check({tag, "_rst_ready"}, {31'b0, dut.uPS2.scan_ready}, 32'd0);
    check({tag, "_rst_code"}, {24'b0, dut.uPS2.scan_code}, 32'd0);
    check({tag, "_rst_vga"}, {VGA_SYNC, VGA_CLK, VGA_BLANK, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B},
          {5'b00011, 12'h000});
    we_cnt = 0;
    KEY0 = 1'b0;
    @(negedge CLOCK_50);
    check({tag, "_init_we"}, {31'b0, dut.uCPU.mem_WE}, 32'd1);
    cyc(1100);
    @(negedge CLOCK_50);
    check({tag, "_init_writes"}, we_cnt, 1024);
    check({tag, "_idle_we"}, {31'b0, dut.uCPU.mem_WE}, 32'd0);
    check({tag, "_idle_addr"}, {16'b0, dut.uCPU.mem_addr}, 32'h03F0);
    check_status({tag, "_post"});
  endtask

  task automatic vga_check(input string tag);
    int t;
    int w;
    logic [5:0] s;
    logic [3:0] er, eg, eb;
    logic       c0;
    s  = model_status();
    er = (s[0] || s[4]) ? 4'hF : 4'h0;
    eg = (s[1] || s[5]) ? 4'hF : 4'h0;
    eb = (s[2] || s[3]) ? 4'hF : 4'h0;
    t = 0;
    while (VGA_BLANK !== 1'b1 && t < 2000) begin @(negedge CLOCK_50); t++; end
    check({tag, "_active_wait"}, {31'b0, t < 2000}, 32'd1);
    check({tag, "_R"}, {28'b0, VGA_R}, {28'b0, er});
    check({tag, "_G"}, {28'b0, VGA_G}, {28'b0, eg});
    check({tag, "_B"}, {28'b0, VGA_B}, {28'b0, eb});
    c0 = VGA_CLK;
    @(negedge CLOCK_50);
    check({tag, "_pixclk"}, {31'b0, VGA_CLK}, {31'b0, ~c0});
    t = 0;
    while (VGA_BLANK !== 1'b0 && t < 2000) begin @(negedge CLOCK_50); t++; end
    check({tag, "_blank_wait"}, {31'b0, t < 2000}, 32'd1);
    check({tag, "_blank_rgb"}, {20'b0, VGA_R, VGA_G, VGA_B}, 32'd0);
    t = 0;
    while (VGA_HS !== 1'b1 && t < 4000) begin @(negedge CLOCK_50); t++; end
    while (VGA_HS !== 1'b0 && t < 4000) begin @(negedge CLOCK_50); t++; end
    check({tag, "_hs_wait"}, {31'b0, t < 4000}, 32'd1);
    w = 0;
    while (VGA_HS === 1'b0 && w < 1000) begin @(negedge CLOCK_50); w++; end
    check({tag, "_hs_width"}, w, 192);
  endtask

  initial begin
    logic [7:0] codes [10];
    codes = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h2D, 8'hF0, 8'hE0, 8'h15, 8'h5A};
    model_reset();

    do_reset("por");

    do_frame(8'h1D, 1'b0, "w_make");
    do_frame(8'hF0, 1'b0, "w_brk0");
    do_frame(8'h1D, 1'b0, "w_brk1");
    do_frame(8'h29, 1'b0, "sp_make");
    do_frame(8'hF0, 1'b0, "sp_brk0");
    do_frame(8'h29, 1'b0, "sp_brk1");
    do_frame(8'h1D, 1'b0, "wd_w");
    do_frame(8'h23, 1'b0, "wd_d");
    do_frame(8'hF0, 1'b0, "d_brk0");
    do_frame(8'h23, 1'b0, "d_brk1");
    do_frame(8'h15, 1'b0, "untracked");
    do_frame(8'hE0, 1'b0, "ext");

    // Partial frame interrupted by reset must not corrupt the next frame
    send_bits(8'h1C, 1'b0, 5);
    do_reset("midframe");
    do_frame(8'h1D, 1'b0, "after_rst");
    do_frame(8'hF0, 1'b0, "after_rst_brk0");
    do_frame(8'h1D, 1'b0, "after_rst_brk1");

    do_frame(8'h2D, 1'b0, "r_make");
    vga_check("vga_r");
    do_frame(8'hF0, 1'b0, "badpar_brk0");
    do_frame(8'h2D, 1'b1, "r_badpar");

    // Partial frame abandoned long enough to time out
    send_bits(8'h1B, 1'b0, 4);
    cyc(50100);
    do_frame(8'h1C, 1'b0, "after_timeout");

    for (int n = 0; n < 40; n++) begin
      int  idx;
      bit  bad;
      idx = int'($urandom_range(0, 9));
      bad = ($urandom_range(0, 6) == 0);
      do_frame(codes[idx], bad, $sformatf("rnd%0d", n));
    end
    vga_check("vga_rnd");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_top.md
Name: cpu_top

Overview:
- Top-level of the keyboard-driven display system: PS/2 receiver plus key-status decoder (instance uPS2), memory/control block with a 1024x16 BRAM and a memory-mapped key-status register (instance uCPU), and a 640x480 VGA timing/colour stage.
- Key state for W, A, S, D, Space and R is tracked live.
- Software and the bench read key state at STATUS_ADDR through the BRAM Port-A read path.

Parameters:
- STATUS_ADDR, 16'h03F0, word address of the read-only key-status register.
- MEM_WORDS, 1024, BRAM depth; address bits [9:0] used.
- PS2_TIMEOUT, 50000, idle cycles (1 ms) after which a partial PS/2 frame is discarded.

Ports:
- CLOCK_50 in 1 50 MHz system clock.
- KEY0 in 1 asynchronous, active-high reset.
- PS2_CLK in 1 keyboard clock, asynchronous.
- PS2_DAT in 1 keyboard data, asynchronous.
- VGA_SYNC out 1 constant 0.
- VGA_CLK out 1 25 MHz pixel clock (CLOCK_50/2).
- VGA_BLANK out 1 high during active video.
- VGA_HS out 1 hsync, active low.
- VGA_VS out 1 vsync, active low.
- VGA_R out 4 red.
- VGA_G out 4 green.
- VGA_B out 4 blue.

Behaviour:
Reset:
- On KEY0=1: all counters 0, scan_code=0, scan_ready=0, break_pending=0, key_status=0.
- VGA outputs low except HS/VS, which are high.

Bench-visible internal signals (hierarchical names are fixed):
- uPS2: scan_code[7:0] and scan_ready are registers; key_status_out[5:0] is an output.
- uCPU: key_status[5:0] is an input driven by uPS2.key_status_out; mem_addr[15:0], mem_WE and mem_dout[15:0] are nets.

PS/2 receive:
- Two-flop synchronise PS2_CLK and PS2_DAT; sample data on each synchronised falling edge.
- Frame is 11 bits: start 0, 8 data LSB-first, odd parity, stop 1.
- Valid frame: scan_code updated and scan_ready high for exactly one cycle. Parity or start/stop error: frame dropped.
- No falling edge for PS2_TIMEOUT cycles: bit counter cleared.

Decoder:
- Acts on the clock edge where scan_ready=1; key_status_out is valid the next cycle.
- Bit map: 0=W(1D), 1=A(1C), 2=S(1B), 3=D(23), 4=Space(29), 5=R(2D).
- F0: sets break_pending; status unchanged.
- E0: ignored; break_pending preserved.
- Tracked code with break_pending=0: set its bit. With break_pending=1: clear its bit.
- Any non-F0/E0 code clears break_pending. Untracked codes change no status bit.
- Multiple keys may be held; bits are independent. Repeated makes are idempotent.

uCPU memory:
- Port A: synchronous write when mem_WE=1. Registered read, 1-cycle latency.
- mem_dout = {10'b0, key_status} (registered) when the previous-cycle mem_addr equals STATUS_ADDR; otherwise BRAM[addr[9:0]].
- Writes to STATUS_ADDR are ignored.
- After reset, a sequencer writes 0 to words 0..1023 (mem_WE=1, one per cycle).
- It then idles with mem_WE=0 and mem_addr=STATUS_ADDR.

VGA:
- Pixel enable on every other CLOCK_50 cycle.
- h total 800: 640 visible, 16 front porch, 96 sync, 48 back porch.
- v total 525: 480 visible, 10 front porch, 2 sync, 33 back porch.
- Active area:
  - R=4'hF if W or Space pressed.
  - G=4'hF if A or R pressed.
  - B=4'hF if S or D pressed.
- Colours are 0 during blanking.

Decomposition:
- Shared package: STATUS_ADDR, scan-code constants (W, A, S, D, SPACE, R, BREAK=F0, EXT=E0), key-bit index constants, VGA timing constants.
- One natural sub-module: ps2_keys (receiver plus decoder, instance uPS2).
- Memory control and VGA stay in the top or in uCPU.

Test Plan:
- Force scan_code=1D with a 1-cycle scan_ready, then read STATUS_ADDR -> PS2=CPU=MEM[5:0]=000001.
- Send F0 then 1D -> all three read 000000.
- Send 29 -> all three 010000; then F0, 29 -> 000000.
- Send 1D then 23 -> all three 001001; then F0, 23 -> 000001.
- Send untracked 15, then E0 -> status unchanged. Assert KEY0 mid-frame -> status 000000 and the partial frame is dropped.
- Bit-bang a serial PS/2 frame for 2D with good parity -> status bit5=1 and VGA_G=F in active area. Same frame with bad parity -> no change.
